sb_drain_cache_writer: RTL
==========================

Name: sb_drain_cache_writer

Overview:
- Cache-side responder for the store buffer drain path. It accepts one {addr, data} entry per handshake and writes the word into a small direct-mapped, write-back, write-allocate data cache.
- On a miss it evicts the dirty victim line to main memory, then fills the target line before the write completes.
- It sits between the store buffer drain output and the memory interface.

Parameters:
- ADDR_WIDTH, 32, address width; equals the store buffer address field width.
- DATA_WIDTH, 32, word width; equals the store buffer data field width.
- NLINES, 4, number of cache lines (power of 2).
- LINE_WORDS, 4, words per line (power of 2).

Ports:
- clk  in  1  system clock
- reset  in  1  reset; asynchronous, active-low
- sb_valid  in  1  store buffer presents a drain entry
- sb_entry  in  ADDR_WIDTH+DATA_WIDTH  {addr[63:32], data[31:0]}
- sb_ready  out  1  writer accepts the entry on this edge
- wr_done  out  1  one-cycle pulse: accepted entry is written into the cache
- mem_req  out  1  memory request
- mem_we  out  1  1 = line writeback, 0 = line fill
- mem_addr  out  ADDR_WIDTH  line-aligned address (low log2(LINE_WORDS)+2 bits are 0)
- mem_wdata  out  LINE_WORDS*DATA_WIDTH  victim line; word0 in bits [31:0]
- mem_rdata  in  LINE_WORDS*DATA_WIDTH  fill line; same packing as mem_wdata
- mem_ack  in  1  memory completes the request this edge

Behaviour:
- Address split (defaults):
  - byte bits [1:0] ignored
  - word offset [3:2]
  - index [5:4]
  - tag [31:6]
- Reset (reset=0, async):
  - state=IDLE
  - all valid and dirty bits cleared
  - sb_ready=1, wr_done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0
  - Takes effect immediately, including mid-transaction; any in-flight entry is dropped.
- States: IDLE, CHECK, EVICT, FILL.
- IDLE:
  - sb_ready=1 (combinational on state).
  - On sb_valid & sb_ready at an edge: latch sb_entry, go to CHECK.
  - sb_ready=0 in every other state; a held sb_valid is never consumed twice.
- CHECK (one cycle): hit = valid[idx] & tag match.
  - Hit: at the edge, write the word, set dirty[idx], pulse wr_done (registered, high the next cycle), go to IDLE.
  - Miss & valid & dirty: go to EVICT.
  - Otherwise: go to FILL.
- EVICT:
  - mem_req=1, mem_we=1, mem_addr={victim tag, idx, 0}, mem_wdata=victim line.
  - Outputs stay stable until mem_ack is sampled high.
  - Then clear dirty and go to FILL.
- FILL:
  - mem_req=1, mem_we=0, mem_addr=line-aligned latched addr.
  - On mem_ack: install mem_rdata, set tag, valid=1, dirty=0, go to CHECK (which then hits).
- Memory handshake:
  - mem_req drops the cycle after the acking edge.
  - mem_ack while mem_req=0 is ignored.
  - mem_ack may arrive on the first request cycle.
- Latency:
  - Hit: wr_done is high 2 cycles after the accept edge.
  - Clean miss: fill ack + 2.
  - Dirty miss: evict ack, then fill ack, then + 2.
- Throughput: at most one entry per 2 cycles on hits (IDLE→CHECK→IDLE).
- Full-line write is not special-cased; fill always precedes the write.

Test Plan:
- Reset: hold reset=0 with random inputs, then release → sb_ready=1, mem_req=0, wr_done=0, no spurious wr_done.
- Cold miss: sb_entry={0x0000_0104, 0xAABB_CCDD}, mem_rdata all words 0x1111_1111, ack after 3 cycles →
  - mem_req=1, mem_we=0, mem_addr=0x0000_0100
  - wr_done 2 cycles after ack
  - line0 = {w3=0x11111111, w2=0x11111111, w1=0xAABBCCDD, w0=0x11111111}, dirty
- Hit: then {0x0000_0108, 0x0000_1234} → no mem_req, wr_done exactly 2 cycles after accept, line0 w2=0x00001234.
- Dirty eviction: then {0x0000_0148, 0xDEAD_BEEF} →
  - EVICT first: mem_we=1, mem_addr=0x0000_0100, mem_wdata={0x11111111, 0x00001234, 0xAABBCCDD, 0x11111111}
  - then FILL: mem_addr=0x0000_0140
  - then wr_done
- Backpressure: hold sb_valid=1 with two different entries across a miss → each is accepted exactly once; sb_ready=0 throughout EVICT/FILL/CHECK.
- Reset mid-FILL: assert reset while mem_req=1 → mem_req=0 immediately (same cycle); after release, an access to 0x0000_0104 misses and issues a fill.

Source files
------------

// File: rtl/sb_drain_cache_writer.sv
// sb_drain_cache_writer
//   Cache-side responder for the store buffer drain path. Each accepted
//   {addr, data} entry is written into a small direct-mapped, write-back,
//   write-allocate data cache. A miss on a dirty line first writes the victim
//   line back to memory, then fills the target line, then performs the write.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-low reset
//   sb_valid   store buffer presents a drain entry
//   sb_entry   {addr, data}
//   sb_ready   entry is accepted on this edge (high only in IDLE)
//   wr_done    one-cycle pulse: the accepted entry has been written
//   mem_req    memory request
//   mem_we     1 = line writeback, 0 = line fill
//   mem_addr   line-aligned memory address
//   mem_wdata  victim line, word0 in the least significant bits
//   mem_rdata  fill line, same packing as mem_wdata
//   mem_ack    memory completes the request on this edge
module sb_drain_cache_writer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NLINES     = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             sb_valid,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] sb_entry,
  output logic                             sb_ready,
  output logic                             wr_done,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] mem_rdata,
  input  logic                             mem_ack
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(NLINES);
  localparam int LOW_W  = OFF_W + 2;                 // word offset + byte bits
  localparam int TAG_W  = ADDR_WIDTH - IDX_W - LOW_W;
  localparam int LINE_W = LINE_WORDS * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    EVICT = 2'd2,
    FILL  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]       data_q [NLINES];
  logic [LINE_W-1:0]       data_d [NLINES];
  logic [TAG_W-1:0]        tag_q [NLINES];
  logic [TAG_W-1:0]        tag_d [NLINES];
  logic [NLINES-1:0]       valid_q, valid_d;
  logic [NLINES-1:0]       dirty_q, dirty_d;
  logic                    wr_done_q, wr_done_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]       mem_wdata_q, mem_wdata_d;

  logic [IDX_W-1:0]        idx_s;
  logic [OFF_W-1:0]        off_s;
  logic [TAG_W-1:0]        tag_s;
  logic                    hit_s;
  logic                    ack_s;
  logic [ADDR_WIDTH-1:0]   fill_addr_s;
  logic [ADDR_WIDTH-1:0]   victim_addr_s;
  logic                    unused_s;

  // Address decode of the latched entry.
  assign idx_s         = addr_q[LOW_W +: IDX_W];
  assign off_s         = addr_q[2 +: OFF_W];
  assign tag_s         = addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign hit_s         = valid_q[idx_s] && (tag_q[idx_s] == tag_s);
  assign fill_addr_s   = {addr_q[ADDR_WIDTH-1:LOW_W], {LOW_W{1'b0}}};
  assign victim_addr_s = {tag_q[idx_s], idx_s, {LOW_W{1'b0}}};
  // An ack is only meaningful while a request is outstanding.
  assign ack_s         = mem_ack & mem_req_q;
  // Byte-select bits play no part in a word-granular cache.
  assign unused_s      = ^addr_q[1:0];

  assign sb_ready  = (state_q == IDLE);
  assign wr_done   = wr_done_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Next-state, cache-array update and registered-output computation.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    data_d      = data_q;
    tag_d       = tag_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    wr_done_d   = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (sb_valid) begin
          addr_d  = sb_entry[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
          wdata_d = sb_entry[DATA_WIDTH-1:0];
          state_d = CHECK;
        end else begin
          state_d = IDLE;
        end
      end

      CHECK: begin
        if (hit_s) begin
          data_d[idx_s][DATA_WIDTH*off_s +: DATA_WIDTH] = wdata_q;
          dirty_d[idx_s] = 1'b1;
          wr_done_d      = 1'b1;
          state_d        = IDLE;
        end else if (valid_q[idx_s] && dirty_q[idx_s]) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = victim_addr_s;
          mem_wdata_d = data_q[idx_s];
          state_d     = EVICT;
        end else begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = fill_addr_s;
          mem_wdata_d = '0;
          state_d     = FILL;
        end
      end

      EVICT: begin
        // The fill request follows the writeback without a gap.
        if (ack_s) begin
          dirty_d[idx_s] = 1'b0;
          mem_req_d      = 1'b1;
          mem_we_d       = 1'b0;
          mem_addr_d     = fill_addr_s;
          mem_wdata_d    = '0;
          state_d        = FILL;
        end else begin
          state_d = EVICT;
        end
      end

      FILL: begin
        // Back to CHECK, which is then guaranteed to hit.
        if (ack_s) begin
          data_d[idx_s]  = mem_rdata;
          tag_d[idx_s]   = tag_s;
          valid_d[idx_s] = 1'b1;
          dirty_d[idx_s] = 1'b0;
          mem_req_d      = 1'b0;
          mem_we_d       = 1'b0;
          mem_addr_d     = '0;
          state_d        = CHECK;
        end else begin
          state_d = FILL;
        end
      end

      default: begin
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        state_d     = IDLE;
      end
    endcase
  end

  // State, cache arrays and registered outputs; reset drops any in-flight entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      wr_done_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int i = 0; i < NLINES; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      wr_done_q   <= wr_done_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      for (int i = 0; i < NLINES; i++) begin
        data_q[i] <= data_d[i];
        tag_q[i]  <= tag_d[i];
      end
    end
  end

endmodule
